// File: rtl/pcie_tx_cpl_arb.sv
// pcie_tx_cpl_arb
//   2:1 packet-atomic round-robin arbiter merging two AXI-S completion
//   streams (MMIO responders) into one TX stream toward the port mux.
//   The output is fully registered through a 2-entry skid buffer, so
//   m_tready never reaches s*_tready combinationally.
//
// Ports
//   clk, rst_n                 core clock, async active-low reset
//   s{0,1}_tvalid/tready/tlast source handshake and end of packet
//   s{0,1}_tdata/tkeep         beat payload and byte enables
//   s{0,1}_tuser_vendor        sideband, passed through unchanged
//   m_tvalid/tready/tlast      merged output handshake
//   m_tdata/tkeep/tuser_vendor merged output payload
//   pkt_cnt0/pkt_cnt1          packets forwarded per source (wrapping)
//   busy                       packet in progress or output buffer occupied
module pcie_tx_cpl_arb #(
    parameter int DATA_W = 512,
    parameter int USER_W = 10,
    parameter int KEEP_W = DATA_W / 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s0_tvalid,
    output logic              s0_tready,
    input  logic              s0_tlast,
    input  logic [DATA_W-1:0] s0_tdata,
    input  logic [KEEP_W-1:0] s0_tkeep,
    input  logic [USER_W-1:0] s0_tuser_vendor,
    input  logic              s1_tvalid,
    output logic              s1_tready,
    input  logic              s1_tlast,
    input  logic [DATA_W-1:0] s1_tdata,
    input  logic [KEEP_W-1:0] s1_tkeep,
    input  logic [USER_W-1:0] s1_tuser_vendor,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              m_tlast,
    output logic [DATA_W-1:0] m_tdata,
    output logic [KEEP_W-1:0] m_tkeep,
    output logic [USER_W-1:0] m_tuser_vendor,
    output logic [CNT_W-1:0]  pkt_cnt0,
    output logic [CNT_W-1:0]  pkt_cnt1,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_e;

    state_e             state_q, state_d;
    logic               rr_ptr_q, rr_ptr_d;
    logic               skid_full_q, skid_full_d;
    logic               valid0_q, valid0_d;
    logic               last0_q, last0_d, last1_q, last1_d;
    logic [DATA_W-1:0]  data0_q, data0_d, data1_q, data1_d;
    logic [KEEP_W-1:0]  keep0_q, keep0_d, keep1_q, keep1_d;
    logic [USER_W-1:0]  user0_q, user0_d, user1_q, user1_d;
    logic [CNT_W-1:0]   cnt0_q, cnt0_d, cnt1_q, cnt1_d;

    logic               gnt0, gnt1, acc0, acc1, acc, pop;
    logic               in_last;
    logic [DATA_W-1:0]  in_data;
    logic [KEEP_W-1:0]  in_keep;
    logic [USER_W-1:0]  in_user;

    always_comb begin
        // NOTE: every signal gets a default up front so no path can infer a latch.
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Round-robin only breaks ties; a lone requester always wins.
                if (s0_tvalid && s1_tvalid) begin
                    gnt0 = ~rr_ptr_q;
                    gnt1 = rr_ptr_q;
                end else begin
                    gnt0 = s0_tvalid;
                    gnt1 = s1_tvalid;
                end
            end
            LOCK0:   gnt0 = 1'b1;
            LOCK1:   gnt1 = 1'b1;
            default: ;
        endcase

        s0_tready = gnt0 & ~skid_full_q;
        s1_tready = gnt1 & ~skid_full_q;
        acc0      = s0_tvalid & s0_tready;
        acc1      = s1_tvalid & s1_tready;
        acc       = acc0 | acc1;
        pop       = valid0_q & m_tready;

        in_last = gnt1 ? s1_tlast        : s0_tlast;
        in_data = gnt1 ? s1_tdata        : s0_tdata;
        in_keep = gnt1 ? s1_tkeep        : s0_tkeep;
        in_user = gnt1 ? s1_tuser_vendor : s0_tuser_vendor;

        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        cnt0_d      = cnt0_q;
        cnt1_d      = cnt1_q;
        skid_full_d = skid_full_q;
        valid0_d    = valid0_q;
        last0_d     = last0_q;
        data0_d     = data0_q;
        keep0_d     = keep0_q;
        user0_d     = user0_q;
        last1_d     = last1_q;
        data1_d     = data1_q;
        keep1_d     = keep1_q;
        user1_d     = user1_q;

        if (acc) begin
            if (in_last) begin
                state_d  = IDLE;
                rr_ptr_d = acc0;  // the port just served loses the next tie
                if (acc0) cnt0_d = cnt0_q + CNT_W'(1);
                else      cnt1_d = cnt1_q + CNT_W'(1);
            end else begin
                state_d = acc1 ? LOCK1 : LOCK0;
            end
        end

        // Entry0 faces the output; entry1 only absorbs the one beat that can
        // arrive in the cycle m_tready drops, since tready is a registered view.
        if (pop && skid_full_q) begin
            valid0_d    = 1'b1;
            last0_d     = last1_q;
            data0_d     = data1_q;
            keep0_d     = keep1_q;
            user0_d     = user1_q;
            skid_full_d = 1'b0;
        end else if (acc) begin
            if (!valid0_q || pop) begin
                valid0_d = 1'b1;
                last0_d  = in_last;
                data0_d  = in_data;
                keep0_d  = in_keep;
                user0_d  = in_user;
            end else begin
                last1_d     = in_last;
                data1_d     = in_data;
                keep1_d     = in_keep;
                user1_d     = in_user;
                skid_full_d = 1'b1;
            end
        end else if (pop) begin
            valid0_d = 1'b0;
        end
    end

    // NOTE: payload registers are reset too because every output must read 0 in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= 1'b0;
            cnt0_q      <= '0;
            cnt1_q      <= '0;
            skid_full_q <= 1'b0;
            valid0_q    <= 1'b0;
            last0_q     <= 1'b0;
            data0_q     <= '0;
            keep0_q     <= '0;
            user0_q     <= '0;
            last1_q     <= 1'b0;
            data1_q     <= '0;
            keep1_q     <= '0;
            user1_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments so all flops update from pre-edge values.
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            cnt0_q      <= cnt0_d;
            cnt1_q      <= cnt1_d;
            skid_full_q <= skid_full_d;
            valid0_q    <= valid0_d;
            last0_q     <= last0_d;
            data0_q     <= data0_d;
            keep0_q     <= keep0_d;
            user0_q     <= user0_d;
            last1_q     <= last1_d;
            data1_q     <= data1_d;
            keep1_q     <= keep1_d;
            user1_q     <= user1_d;
        end
    end

    assign m_tvalid       = valid0_q;
    assign m_tlast        = last0_q;
    assign m_tdata        = data0_q;
    assign m_tkeep        = keep0_q;
    assign m_tuser_vendor = user0_q;
    assign pkt_cnt0       = cnt0_q;
    assign pkt_cnt1       = cnt1_q;
    assign busy           = (state_q != IDLE) | valid0_q;

endmodule

// File: tb/tb_pcie_tx_cpl_arb.sv
// Testbench for pcie_tx_cpl_arb: directed stimulus, expected output beats
// queued up front in hand-worked order, a negedge monitor compares them.
module tb_pcie_tx_cpl_arb;

    localparam int DATA_W = 512;
    localparam int USER_W = 10;
    localparam int KEEP_W = DATA_W / 8;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              s0_tvalid, s0_tready, s0_tlast;
    logic [DATA_W-1:0] s0_tdata;
    logic [KEEP_W-1:0] s0_tkeep;
    logic [USER_W-1:0] s0_tuser_vendor;
    logic              s1_tvalid, s1_tready, s1_tlast;
    logic [DATA_W-1:0] s1_tdata;
    logic [KEEP_W-1:0] s1_tkeep;
    logic [USER_W-1:0] s1_tuser_vendor;
    logic              m_tvalid, m_tready, m_tlast;
    logic [DATA_W-1:0] m_tdata;
    logic [KEEP_W-1:0] m_tkeep;
    logic [USER_W-1:0] m_tuser_vendor;
    logic [CNT_W-1:0]  pkt_cnt0, pkt_cnt1;
    logic              busy;

    always #5 clk = ~clk;

    pcie_tx_cpl_arb #(.DATA_W(DATA_W), .USER_W(USER_W), .KEEP_W(KEEP_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .s0_tvalid(s0_tvalid), .s0_tready(s0_tready), .s0_tlast(s0_tlast),
        .s0_tdata(s0_tdata), .s0_tkeep(s0_tkeep), .s0_tuser_vendor(s0_tuser_vendor),
        .s1_tvalid(s1_tvalid), .s1_tready(s1_tready), .s1_tlast(s1_tlast),
        .s1_tdata(s1_tdata), .s1_tkeep(s1_tkeep), .s1_tuser_vendor(s1_tuser_vendor),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
        .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tuser_vendor(m_tuser_vendor),
        .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1), .busy(busy)
    );

    typedef struct packed {
        logic [31:0] tag;
        logic        last;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   acc_cnt [2];
    logic lock_active = 1'b0;

    function automatic logic [DATA_W-1:0] mk_data(input logic [31:0] t);
        return {16{t}};
    endfunction

    function automatic logic [KEEP_W-1:0] mk_keep(input logic [31:0] t);
        return {8{t[7:0] ^ 8'hA5}};
    endfunction

    function automatic logic [USER_W-1:0] mk_user(input logic [31:0] t);
        return t[9:0] ^ t[19:10] ^ 10'h2C3;
    endfunction

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [31:0] tag, input logic last);
        exp_t e;
        e.tag  = tag;
        e.last = last;
        exp_q.push_back(e);
    endtask

    task automatic set_port(input int p, input logic v, input logic [31:0] tag, input logic last);
        if (p == 0) begin
            s0_tvalid = v; s0_tlast = last; s0_tdata = mk_data(tag);
            s0_tkeep = mk_keep(tag); s0_tuser_vendor = mk_user(tag);
        end else begin
            s1_tvalid = v; s1_tlast = last; s1_tdata = mk_data(tag);
            s1_tkeep = mk_keep(tag); s1_tuser_vendor = mk_user(tag);
        end
    endtask

    // Starts and ends at posedge+1; tags are tag0, tag0+1, ...
    task automatic send_pkt(input int p, input logic [31:0] tag0, input int n);
        bit done;
        for (int b = 0; b < n; b++) begin
            done = 1'b0;
            set_port(p, 1'b1, tag0 + 32'(b), (b == n - 1));
            for (int w = 0; w < 1000 && !done; w++) begin
                @(negedge clk);
                if ((p == 0) ? s0_tready : s1_tready) begin
                    @(posedge clk);
                    acc_cnt[p]++;
                    done = 1'b1;
                end
            end
            if (!done) check("accept_timeout", done, 1);
            #1;
        end
        set_port(p, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic wait_drain(input string name);
        for (int w = 0; w < 200 && exp_q.size() != 0; w++) @(negedge clk);
        check(name, exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_port(0, 1'b0, 32'h0, 1'b0);
        set_port(1, 1'b0, 32'h0, 1'b0);
        m_tready = 1'b1;
        acc_cnt[0] = 0;
        acc_cnt[1] = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares each transferred beat with the queue head and checks
    // that m_* holds while stalled.
    initial begin
        logic              stall_prev = 1'b0;
        logic [DATA_W-1:0] d_prev;
        logic              l_prev;
        exp_t              e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    check("stall_valid", m_tvalid, 1);
                    check("stall_data", m_tdata, d_prev);
                    check("stall_last", m_tlast, l_prev);
                end
                if (m_tvalid && m_tready) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_beat: actual=%0h required=none", m_tdata[31:0]);
                    end else begin
                        e = exp_q.pop_front();
                        check("m_tdata", m_tdata, mk_data(e.tag));
                        check("m_tkeep", m_tkeep, mk_keep(e.tag));
                        check("m_tuser", m_tuser_vendor, mk_user(e.tag));
                        check("m_tlast", m_tlast, e.last);
                    end
                end
                stall_prev = m_tvalid && !m_tready;
                d_prev     = m_tdata;
                l_prev     = m_tlast;
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        m_tready = 1'b0;
        set_port(0, 1'b0, 32'h0, 1'b0);
        set_port(1, 1'b0, 32'h0, 1'b0);
        #3;
        check("rst_m_tvalid", m_tvalid, 0);
        check("rst_m_tdata", m_tdata, 0);
        check("rst_busy", busy, 0);
        check("rst_cnt0", pkt_cnt0, 0);
        check("rst_cnt1", pkt_cnt1, 0);

        // Single beat from s0: visible one cycle after acceptance.
        do_reset();
        push_exp(32'h4A, 1'b1);
        set_port(0, 1'b1, 32'h4A, 1'b1);
        @(negedge clk);
        check("t1_s0_ready", s0_tready, 1);
        check("t1_s1_ready", s1_tready, 0);
        check("t1_no_early_valid", m_tvalid, 0);
        @(posedge clk);
        #1;
        set_port(0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        check("t1_latency_valid", m_tvalid, 1);
        check("t1_cnt0", pkt_cnt0, 1);
        check("t1_s1_ready_after", s1_tready, 0);
        wait_drain("t1_drain");
        check("t1_idle_busy", busy, 0);

        // Contention: alternating single-beat packets, s0 first after reset.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            push_exp(32'h100 + 32'(i), 1'b1);
            push_exp(32'h200 + 32'(i), 1'b1);
        end
        fork
            for (int i = 0; i < 4; i++) send_pkt(0, 32'h100 + 32'(i), 1);
            for (int j = 0; j < 4; j++) send_pkt(1, 32'h200 + 32'(j), 1);
        join
        wait_drain("t2_drain");
        check("t2_cnt0", pkt_cnt0, 4);
        check("t2_cnt1", pkt_cnt1, 4);

        // Packet lock: s1 raises valid mid s0 packet and must wait.
        do_reset();
        push_exp(32'h300, 1'b0);
        push_exp(32'h301, 1'b0);
        push_exp(32'h302, 1'b1);
        push_exp(32'h400, 1'b1);
        fork
            begin
                lock_active = 1'b1;
                send_pkt(0, 32'h300, 3);
                lock_active = 1'b0;
            end
            begin
                @(posedge clk);
                #1;
                send_pkt(1, 32'h400, 1);
            end
            for (int c = 0; c < 8; c++) begin
                @(negedge clk);
                if (lock_active && s1_tvalid) check("t3_s1_blocked", s1_tready, 0);
            end
        join
        wait_drain("t3_drain");
        check("t3_cnt0", pkt_cnt0, 1);
        check("t3_cnt1", pkt_cnt1, 1);

        // Backpressure: 5 stalled edges, only two beats fit in the buffer.
        do_reset();
        m_tready = 1'b0;
        for (int i = 0; i < 5; i++) push_exp(32'h500 + 32'(i), (i == 4));
        fork
            send_pkt(0, 32'h500, 5);
            begin
                repeat (4) @(posedge clk);
                @(negedge clk);
                check("t4_accepted", acc_cnt[0], 2);
                check("t4_s0_ready", s0_tready, 0);
                check("t4_m_tvalid", m_tvalid, 1);
                @(posedge clk);
                #1;
                m_tready = 1'b1;
            end
        join
        wait_drain("t4_drain");
        check("t4_total_acc", acc_cnt[0], 5);
        check("t4_cnt0", pkt_cnt0, 1);

        // Reset after beat 2 of a 4-beat s1 packet.
        do_reset();
        push_exp(32'h600, 1'b0);
        set_port(1, 1'b1, 32'h600, 1'b0);
        @(negedge clk);
        check("t5_beat1_ready", s1_tready, 1);
        @(posedge clk);
        #1;
        set_port(1, 1'b1, 32'h601, 1'b0);
        @(negedge clk);
        check("t5_beat2_ready", s1_tready, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        set_port(1, 1'b0, 32'h0, 1'b0);
        #1;
        check("t5_rst_m_tvalid", m_tvalid, 0);
        check("t5_rst_cnt0", pkt_cnt0, 0);
        check("t5_rst_cnt1", pkt_cnt1, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_no_pending", exp_q.size(), 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        push_exp(32'h700, 1'b1);
        send_pkt(0, 32'h700, 1);
        wait_drain("t5_drain");
        check("t5_after_cnt0", pkt_cnt0, 1);
        check("t5_after_cnt1", pkt_cnt1, 0);
        check("t5_after_busy", busy, 0);

        // Counter wrap on port 0; port 1 holds its single packet.
        do_reset();
        push_exp(32'h800, 1'b1);
        send_pkt(1, 32'h800, 1);
        for (int i = 0; i < 65536; i++) begin
            push_exp(32'h10000 + 32'(i), 1'b1);
            send_pkt(0, 32'h10000 + 32'(i), 1);
            if (i == 65534) check("t6_cnt0_max", pkt_cnt0, 16'hFFFF);
        end
        check("t6_cnt0_wrap", pkt_cnt0, 0);
        check("t6_cnt1_kept", pkt_cnt1, 1);
        wait_drain("t6_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
